// File: rtl/axi_pkg.sv
// AXI4 encodings shared by the cache test memory blocks.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/cache_tb_mem_pkg.sv
// FSM encodings, delay counter width and the default AXI channel structs
// used by the cache test-bench memory responder.
package cache_tb_mem_pkg;

  localparam int DlyWidth = 4;

  localparam int AxiAddrW = 64;
  localparam int AxiDataW = 64;
  localparam int AxiIdW   = 4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} r_state_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [5:0]          atop;
  } axi_aw_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_mem_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts; reserved type acts as INCR.
module axi_mem_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] next_addr
);

  logic [AddrWidth-1:0] step;
  logic [AddrWidth-1:0] incr;
  logic [AddrWidth-1:0] wrap_mask;

  // WRAP keeps the address inside a (len+1)*step aligned window.
  always_comb begin
    step      = AddrWidth'(1) << size;
    incr      = addr + step;
    wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/cache_axi_mem_responder.sv
// AXI4 slave memory: one write and one read burst in flight, word array
// backing store, B/R returned after RespDelay extra cycles.
module cache_axi_mem_responder
  import axi_pkg::*;
  import cache_tb_mem_pkg::*;
#(
  parameter type                   mst_req_t  = axi_req_t,
  parameter type                   mst_resp_t = axi_resp_t,
  parameter int unsigned           AddrWidth  = 64,
  parameter int unsigned           DataWidth  = 64,
  parameter int unsigned           IdWidth    = 4,
  parameter int unsigned           MemWords   = 1024,
  parameter logic [AddrWidth-1:0]  BaseAddr   = 64'h8000_0000,
  parameter int unsigned           RespDelay  = 0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  mst_req_t  axi_req_i,
  output mst_resp_t axi_resp_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffBits   = $clog2(StrbWidth);
  localparam int unsigned IdxBits   = $clog2(MemWords);
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(MemWords * StrbWidth);
  localparam logic [DlyWidth-1:0]  DlyLast  = DlyWidth'((RespDelay > 0) ? RespDelay - 1 : 0);

  // Unsigned offset wraps for addresses below BaseAddr, so one compare suffices.
  function automatic logic in_range(input logic [AddrWidth-1:0] a);
    return (a - BaseAddr) < MemBytes;
  endfunction

  function automatic logic [IdxBits-1:0] word_idx(input logic [AddrWidth-1:0] a);
    return IdxBits'((a - BaseAddr) >> OffBits);
  endfunction

  logic [DataWidth-1:0] mem [MemWords];

  // write path state
  w_state_e             w_state;
  logic [IdWidth-1:0]   w_id;
  logic [AddrWidth-1:0] w_addr, w_next;
  logic [7:0]           w_len, w_cnt;
  logic [2:0]           w_size;
  logic [1:0]           w_burst;
  logic                 w_atop, w_err;
  logic [DlyWidth-1:0]  w_dly;

  // read path state
  r_state_e             r_state;
  logic [IdWidth-1:0]   r_id;
  logic [AddrWidth-1:0] r_addr, r_next, rd_addr;
  logic [7:0]           r_len, r_cnt;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic [DlyWidth-1:0]  r_dly;
  logic [DataWidth-1:0] r_data, rd_word;
  logic                 r_err, rd_hit;

  logic aw_hs, w_hs, ar_hs, r_hs, w_last_beat, mem_we;
  logic unused_lock;

  assign unused_lock = axi_req_i.aw.lock ^ axi_req_i.ar.lock;

  assign aw_hs       = axi_req_i.aw_valid && axi_resp_o.aw_ready;
  assign w_hs        = axi_req_i.w_valid  && axi_resp_o.w_ready;
  assign ar_hs       = axi_req_i.ar_valid && axi_resp_o.ar_ready;
  assign r_hs        = axi_resp_o.r_valid && axi_req_i.r_ready;
  assign w_last_beat = axi_req_i.w.last || (w_cnt == w_len);
  assign mem_we      = w_hs && !w_atop && in_range(w_addr);

  axi_mem_burst_addr #(.AddrWidth(AddrWidth)) u_w_addr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_next)
  );

  axi_mem_burst_addr #(.AddrWidth(AddrWidth)) u_r_addr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_next)
  );

  // Write FSM: accept AW, sink W beats, hold B until taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_atop  <= 1'b0;
      w_err   <= 1'b0;
      w_dly   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_id    <= axi_req_i.aw.id;
          w_addr  <= axi_req_i.aw.addr;
          w_len   <= axi_req_i.aw.len;
          w_size  <= axi_req_i.aw.size;
          w_burst <= axi_req_i.aw.burst;
          w_atop  <= |axi_req_i.aw.atop;
          w_err   <= 1'b0;
          w_cnt   <= '0;
          w_dly   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_cnt  <= w_cnt + 8'd1;
          w_addr <= w_next;
          if (w_atop || !in_range(w_addr) || (axi_req_i.w.last != (w_cnt == w_len)))
            w_err <= 1'b1;
          if (w_last_beat)
            w_state <= (RespDelay > 0) ? W_DELAY : W_RESP;
        end
        W_DELAY: begin
          if (w_dly == DlyLast) w_state <= W_RESP;
          else                  w_dly   <= w_dly + 1'b1;
        end
        W_RESP: if (axi_req_i.b_ready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-strobed array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbWidth; b++)
        if (axi_req_i.w.strb[b])
          mem[word_idx(w_addr)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
    end
  end

  // Address of the word the read data register loads this cycle.
  always_comb begin
    rd_addr = r_next;
    case (r_state)
      R_IDLE:  rd_addr = axi_req_i.ar.addr;
      R_DELAY: rd_addr = r_addr;
      default: ;
    endcase
    rd_hit  = in_range(rd_addr);
    rd_word = rd_hit ? mem[word_idx(rd_addr)] : '0;
  end

  // Read FSM: accept AR, optional delay, stream beats from a data register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_dly   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_id    <= axi_req_i.ar.id;
          r_addr  <= axi_req_i.ar.addr;
          r_len   <= axi_req_i.ar.len;
          r_size  <= axi_req_i.ar.size;
          r_burst <= axi_req_i.ar.burst;
          r_cnt   <= '0;
          r_dly   <= '0;
          if (RespDelay > 0) begin
            r_state <= R_DELAY;
          end else begin
            r_state <= R_DATA;
            r_data  <= rd_word;
            r_err   <= !rd_hit;
          end
        end
        R_DELAY: begin
          if (r_dly == DlyLast) begin
            r_state <= R_DATA;
            r_data  <= rd_word;
            r_err   <= !rd_hit;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        R_DATA: if (r_hs) begin
          if (r_cnt == r_len) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= r_next;
            r_data <= rd_word;
            r_err  <= !rd_hit;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Response channels; everything is forced low while reset is held.
  always_comb begin
    axi_resp_o = '0;
    if (rst_ni) begin
      axi_resp_o.aw_ready = (w_state == W_IDLE);
      axi_resp_o.w_ready  = (w_state == W_DATA);
      axi_resp_o.b_valid  = (w_state == W_RESP);
      axi_resp_o.b.id     = w_id;
      axi_resp_o.b.resp   = w_err ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.ar_ready = (r_state == R_IDLE);
      axi_resp_o.r_valid  = (r_state == R_DATA);
      axi_resp_o.r.id     = r_id;
      axi_resp_o.r.data   = r_data;
      axi_resp_o.r.resp   = r_err ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.r.last   = (r_cnt == r_len);
    end
  end

endmodule

// File: tb/tb_cache_axi_mem_responder.sv
// Directed bench for cache_axi_mem_responder with a word-level memory model.
module tb_cache_axi_mem_responder;
  import axi_pkg::*;
  import cache_tb_mem_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic      clk = 1'b0;
  logic      rst_n;
  axi_req_t  req, req_d;
  axi_resp_t resp, resp_d;
  int        cyc = 0;
  int        n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_axi_mem_responder #(.RespDelay(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_resp_o(resp)
  );

  cache_axi_mem_responder #(.RespDelay(5)) u_dly (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req_d), .axi_resp_o(resp_d)
  );

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;

  logic [63:0] mem_m [int];
  bexp_t       exp_b[$];
  rexp_t       exp_r[$];
  logic [63:0] rx_data[$];
  logic [1:0]  rx_bresp[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'd8192);
  endfunction

  function automatic int m_idx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  // Beat address from plain burst arithmetic (size fixed at 8 bytes).
  function automatic logic [63:0] m_addr(input logic [63:0] start, input int beat,
                                         input int len, input logic [1:0] burst);
    logic [63:0] win, lo;
    if (burst == BURST_FIXED) return start;
    if (burst == BURST_WRAP) begin
      win = 64'((len + 1) * 8);
      lo  = start - (start % win);
      return lo + ((start - lo + 64'(beat * 8)) % win);
    end
    return start + 64'(beat * 8);
  endfunction

  // Compare process: every B/R handshake against the model, R hold stability.
  logic  hold_q;
  axi_r_t r_q;
  always @(negedge clk) begin
    bexp_t eb;
    rexp_t er;
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        check("r_hold_valid", 128'(resp.r_valid), 128'(1));
        check("r_hold_payload", 128'(resp.r), 128'(r_q));
      end
      hold_q <= resp.r_valid && !req.r_ready;
      r_q    <= resp.r;
      if (resp.b_valid && req.b_ready) begin
        rx_bresp.push_back(resp.b.resp);
        if (exp_b.size() == 0) check("b_unexpected", 128'(1), 128'(0));
        else begin
          eb = exp_b.pop_front();
          check("b_id", 128'(resp.b.id), 128'(eb.id));
          check("b_resp", 128'(resp.b.resp), 128'(eb.resp));
        end
      end
      if (resp.r_valid && req.r_ready) begin
        rx_data.push_back(resp.r.data);
        if (exp_r.size() == 0) check("r_unexpected", 128'(1), 128'(0));
        else begin
          er = exp_r.pop_front();
          check("r_id", 128'(resp.r.id), 128'(er.id));
          check("r_data", 128'(resp.r.data), 128'(er.data));
          check("r_resp", 128'(resp.r.resp), 128'(er.resp));
          check("r_last", 128'(resp.r.last), 128'(er.last));
        end
      end
    end
  end

  task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [63:0] base, input logic [7:0] strb,
                          input logic [5:0] atop, input logic [3:0] id);
    int t_aw, t_last, bnd;
    bit err;
    logic [63:0] a, w, d;
    bexp_t e;
    err = 0;
    @(posedge clk); #1;
    req.aw = '0;
    req.aw.addr = addr; req.aw.len = 8'(len); req.aw.size = 3'd3;
    req.aw.burst = burst; req.aw.atop = atop; req.aw.id = id;
    req.aw_valid = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp.aw_ready && bnd < 50);
    if (bnd >= 50) check("aw_timeout", 128'(0), 128'(1));
    t_aw = cyc;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = base + 64'(i);
      req.w.data = d; req.w.strb = strb; req.w.last = (i == len); req.w_valid = 1'b1;
      bnd = 0;
      do begin @(negedge clk); bnd++; end while (!resp.w_ready && bnd < 50);
      if (bnd >= 50) check("w_timeout", 128'(0), 128'(1));
      if (i == 0) check("w_ready_latency", 128'(cyc - t_aw), 128'(1));
      a = m_addr(addr, i, len, burst);
      if (atop != 0 || !m_in_range(a)) err = 1;
      else begin
        w = mem_m.exists(m_idx(a)) ? mem_m[m_idx(a)] : 64'h0;
        for (int b = 0; b < 8; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_m[m_idx(a)] = w;
      end
      t_last = cyc;
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
    e.id = id; e.resp = err ? RESP_SLVERR : RESP_OKAY;
    exp_b.push_back(e);
    req.b_ready = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp.b_valid && bnd < 50);
    if (bnd >= 50) check("b_timeout", 128'(0), 128'(1));
    check("b_latency", 128'(cyc - t_last), 128'(1));
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic push_read_exp(input logic [63:0] addr, input int len,
                               input logic [1:0] burst, input logic [3:0] id);
    logic [63:0] a;
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      a = m_addr(addr, i, len, burst);
      e.id   = id;
      e.data = (m_in_range(a) && mem_m.exists(m_idx(a))) ? mem_m[m_idx(a)] : 64'h0;
      e.resp = m_in_range(a) ? RESP_OKAY : RESP_SLVERR;
      e.last = (i == len);
      exp_r.push_back(e);
    end
  endtask

  task automatic start_read(input logic [63:0] addr, input int len,
                            input logic [1:0] burst, input logic [3:0] id, input bit rdy);
    int bnd;
    push_read_exp(addr, len, burst, id);
    @(posedge clk); #1;
    req.ar = '0;
    req.ar.addr = addr; req.ar.len = 8'(len); req.ar.size = 3'd3;
    req.ar.burst = burst; req.ar.id = id;
    req.ar_valid = 1'b1;
    req.r_ready = rdy;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp.ar_ready && bnd < 50);
    if (bnd >= 50) check("ar_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle);
    int bnd;
    start_read(addr, len, burst, id, !toggle);
    @(negedge clk);
    check("r_valid_latency", 128'(resp.r_valid), 128'(1));
    bnd = 0;
    while (exp_r.size() > 0 && bnd < 100) begin
      @(posedge clk); #1;
      if (toggle) req.r_ready = ~req.r_ready;
      bnd++;
    end
    if (bnd >= 100) check("r_timeout", 128'(0), 128'(1));
    req.r_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, bnd;
    req = '0; req_d = '0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp", 128'(resp), 128'(0));
    check("reset_resp_dly", 128'(resp_d), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_readies", 128'({resp.aw_ready, resp.ar_ready, resp.w_ready}), 128'(3'b110));

    // single write / read
    do_write(64'h8000_0010, 0, BURST_INCR, 64'hDEAD_BEEF_0123_4567, 8'hFF, 6'h0, 4'd1);
    do_read(64'h8000_0010, 0, BURST_INCR, 4'd3, 1'b0);
    check("single_data", 128'(rx_data[rx_data.size()-1]), 128'(64'hDEAD_BEEF_0123_4567));

    // INCR burst with stalled reader
    do_write(64'h8000_0100, 7, BURST_INCR, 64'd0, 8'hFF, 6'h0, 4'd2);
    do_read(64'h8000_0100, 7, BURST_INCR, 4'd4, 1'b1);
    n = rx_data.size();
    for (int i = 0; i < 8; i++) check("incr_order", 128'(rx_data[n-8+i]), 128'(i));

    // WRAP burst
    do_read(64'h8000_0118, 3, BURST_WRAP, 4'd5, 1'b0);
    n = rx_data.size();
    check("wrap_b0", 128'(rx_data[n-4]), 128'(3));
    check("wrap_b1", 128'(rx_data[n-3]), 128'(0));
    check("wrap_b2", 128'(rx_data[n-2]), 128'(1));
    check("wrap_b3", 128'(rx_data[n-1]), 128'(2));

    // FIXED burst
    do_read(64'h8000_0108, 2, BURST_FIXED, 4'd6, 1'b0);
    check("fixed_data", 128'(rx_data[rx_data.size()-1]), 128'(1));

    // partial strobe
    do_write(64'h8000_0300, 0, BURST_INCR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 6'h0, 4'd7);
    do_write(64'h8000_0300, 0, BURST_INCR, 64'h1122_3344_5566_7788, 8'h0F, 6'h0, 4'd8);
    do_read(64'h8000_0300, 0, BURST_INCR, 4'd9, 1'b0);
    check("strobe_data", 128'(rx_data[rx_data.size()-1]), 128'(64'hFFFF_FFFF_5566_7788));

    // out-of-range write below BASE leaves the top word alone
    do_write(64'h8000_1FF8, 0, BURST_INCR, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF, 6'h0, 4'd10);
    do_write(64'h7FFF_FFF8, 0, BURST_INCR, 64'h1234, 8'hFF, 6'h0, 4'd11);
    check("oor_bresp", 128'(rx_bresp[rx_bresp.size()-1]), 128'(RESP_SLVERR));
    do_read(64'h8000_1FF8, 0, BURST_INCR, 4'd12, 1'b0);
    check("oor_untouched", 128'(rx_data[rx_data.size()-1]), 128'(64'hA5A5_5A5A_A5A5_5A5A));
    do_read(64'h7FFF_FFF8, 0, BURST_INCR, 4'd13, 1'b0);
    check("oor_rdata", 128'(rx_data[rx_data.size()-1]), 128'(0));

    // atomic write is discarded with SLVERR
    do_write(64'h8000_0300, 0, BURST_INCR, 64'h0, 8'hFF, 6'h20, 4'd14);
    check("atop_bresp", 128'(rx_bresp[rx_bresp.size()-1]), 128'(RESP_SLVERR));
    do_read(64'h8000_0300, 0, BURST_INCR, 4'd15, 1'b0);
    check("atop_untouched", 128'(rx_data[rx_data.size()-1]), 128'(64'hFFFF_FFFF_5566_7788));

    // reset in the middle of an 8-beat read
    do_write(64'h8000_0200, 7, BURST_INCR, 64'd100, 8'hFF, 6'h0, 4'd1);
    start_read(64'h8000_0200, 7, BURST_INCR, 4'd2, 1'b1);
    bnd = 0;
    while (exp_r.size() > 6 && bnd < 50) begin @(posedge clk); #1; bnd++; end
    if (bnd >= 50) check("mid_rst_timeout", 128'(0), 128'(1));
    rst_n = 1'b0;
    exp_r.delete();
    @(negedge clk);
    check("mid_rst_resp", 128'(resp), 128'(0));
    @(posedge clk); @(negedge clk);
    check("mid_rst_resp_edge", 128'(resp), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_readies", 128'({resp.aw_ready, resp.ar_ready, resp.r_valid}), 128'(3'b110));
    do_read(64'h8000_0200, 7, BURST_INCR, 4'd3, 1'b0);
    check("post_rst_data", 128'(rx_data[rx_data.size()-1]), 128'(107));

    // RespDelay = 5 instance
    @(posedge clk); #1;
    req_d.aw.addr = 64'h8000_0040; req_d.aw.len = 8'd0; req_d.aw.size = 3'd3;
    req_d.aw.burst = BURST_INCR; req_d.aw.id = 4'd2; req_d.aw_valid = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp_d.aw_ready && bnd < 50);
    @(posedge clk); #1;
    req_d.aw_valid = 1'b0;
    req_d.w.data = 64'hCAFE_F00D_1234_5678; req_d.w.strb = 8'hFF; req_d.w.last = 1'b1;
    req_d.w_valid = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp_d.w_ready && bnd < 50);
    t = cyc;
    @(posedge clk); #1;
    req_d.w_valid = 1'b0; req_d.b_ready = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp_d.b_valid && bnd < 50);
    check("dly_b_latency", 128'(cyc - t), 128'(6));
    check("dly_b_resp", 128'({resp_d.b.id, resp_d.b.resp}), 128'({4'd2, RESP_OKAY}));
    @(posedge clk); #1;
    req_d.b_ready = 1'b0;
    req_d.ar.addr = 64'h8000_0040; req_d.ar.len = 8'd0; req_d.ar.size = 3'd3;
    req_d.ar.burst = BURST_INCR; req_d.ar.id = 4'd6; req_d.ar_valid = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp_d.ar_ready && bnd < 50);
    t = cyc;
    @(posedge clk); #1;
    req_d.ar_valid = 1'b0; req_d.r_ready = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!resp_d.r_valid && bnd < 50);
    check("dly_r_latency", 128'(cyc - t), 128'(6));
    check("dly_r_data", 128'(resp_d.r.data), 128'(64'hCAFE_F00D_1234_5678));
    check("dly_r_last", 128'({resp_d.r.last, resp_d.r.resp}), 128'({1'b1, RESP_OKAY}));
    @(posedge clk); #1;
    req_d.r_ready = 1'b0;

    repeat (3) @(posedge clk);
    check("exp_queues_drained", 128'(exp_b.size() + exp_r.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
